// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: PC, start/run/halt FSM, stall and branch handling.
// Ports: clk, reset (async high), start, halt, stall, branch_taken, branch_abs,
//   branch_target, branch_offset -> inst_addr, fetch_valid, done, overrun, cycle_cnt.
// Macro FETCH_CYCLE_CNT_EN builds the saturating RUN-cycle counter on cycle_cnt;
//   without it cycle_cnt is tied to 0.
module instr_fetch_ctrl #(
  parameter int          A          = 4,
  parameter int unsigned START_ADDR = 0,
  parameter int          CW         = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          halt,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic          branch_abs,
  input  logic [A-1:0]  branch_target,
  input  logic [A-1:0]  branch_offset,
  output logic [A-1:0]  inst_addr,
  output logic          fetch_valid,
  output logic          done,
  output logic          overrun,
  output logic [CW-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [A-1:0] PC_START = A'(START_ADDR);
  localparam logic [A-1:0] PC_LAST  = {A{1'b1}};

  state_t       state_q, state_d;
  logic [A-1:0] pc_q, pc_d;
  logic         ovr_q, ovr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= PC_START;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = PC_START;
        end
      end
      S_RUN: begin
        // halt > stall > branch > increment
        if (halt) begin
          state_d = S_HALT;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (branch_taken) begin
          // relative add wraps in A bits by construction
          pc_d = branch_abs ? branch_target
                            : pc_q + branch_offset;
        end else if (pc_q != PC_LAST) begin
          pc_d = pc_q + A'(1);
        end else begin
          state_d = S_HALT;
          ovr_d   = 1'b1;
        end
      end
      S_HALT: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = PC_START;
          ovr_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = PC_START;
      end
    endcase
  end

  always_comb begin
    fetch_valid = (state_q == S_RUN);
    done        = (state_q == S_HALT);
    inst_addr   = pc_q;
    overrun     = ovr_q;
  end

`ifdef FETCH_CYCLE_CNT_EN
  logic [CW-1:0] cnt_q;
  logic          launch;

  assign launch = (state_q != S_RUN) && (state_d == S_RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (launch) begin
      cnt_q <= '0;
    end else if (state_q == S_RUN && cnt_q != {CW{1'b1}}) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign cycle_cnt = cnt_q;
`else
  assign cycle_cnt = '0;
`endif

endmodule
